// File: rtl/axi4_lite_timer.sv
// Memory-mapped 32-bit timer/compare peripheral behind the AXI4-Lite slave adapter.
// Prescaled free-running counter, compare match with optional auto-reload, level irq.
module axi4_lite_timer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_write,
    input  logic [3:0]                byte_en,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      data_valid,
    output logic                      irq
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_STATUS   = 3'd4
    } reg_sel_e;

    logic [2:0]                ctrl;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [DATA_WIDTH-1:0]     count;
    logic [DATA_WIDTH-1:0]     compare;
    logic                      match;
    logic [PRESCALE_WIDTH-1:0] pre;
    logic [ADDR_WIDTH-1:0]     raddr_q;
    logic                      started;

    logic [DATA_WIDTH-1:0]     wmask;
    logic [2:0]                wr_sel;
    logic                      wr_ctrl, wr_prescale, wr_count, wr_compare, clr_match;
    logic                      tick, match_hit;
    logic [DATA_WIDTH-1:0]     count_tick, count_nxt, compare_nxt;
    logic [PRESCALE_WIDTH-1:0] prescale_nxt, pre_nxt;
    logic [DATA_WIDTH-1:0]     rd_mux;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{write_addr[ADDR_WIDTH-1:5], write_addr[1:0]};

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[i*8 +: 8] = {8{byte_en[i]}};
        end
    end

    assign wr_sel      = write_addr[4:2];
    assign wr_ctrl     = mem_write && (wr_sel == REG_CTRL) && byte_en[0];
    assign wr_prescale = mem_write && (wr_sel == REG_PRESCALE) && (|byte_en);
    assign wr_count    = mem_write && (wr_sel == REG_COUNT);
    assign wr_compare  = mem_write && (wr_sel == REG_COMPARE);
    assign clr_match   = mem_write && (wr_sel == REG_STATUS) && byte_en[0] && write_data[0];

    always_comb begin
        tick       = ctrl[0] && (pre == prescale);
        match_hit  = tick && (count == compare);
        count_tick = count;
        if (tick) begin
            count_tick = (match_hit && ctrl[1]) ? '0 : count + 32'd1;
        end
        // Written byte lanes override the tick result; unwritten lanes keep it.
        count_nxt = count_tick;
        if (wr_count) begin
            count_nxt = (count_tick & ~wmask) | (write_data & wmask);
        end

        compare_nxt = compare;
        if (wr_compare) begin
            compare_nxt = (compare & ~wmask) | (write_data & wmask);
        end

        prescale_nxt = prescale;
        if (wr_prescale) begin
            prescale_nxt = (prescale & ~wmask[PRESCALE_WIDTH-1:0])
                         | (write_data[PRESCALE_WIDTH-1:0] & wmask[PRESCALE_WIDTH-1:0]);
        end

        pre_nxt = pre;
        if (wr_prescale) begin
            pre_nxt = '0;
        end else if (ctrl[0]) begin
            pre_nxt = tick ? '0 : pre + PRESCALE_WIDTH'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (read_addr[4:2])
            REG_CTRL:     rd_mux[2:0] = ctrl;
            REG_PRESCALE: rd_mux[PRESCALE_WIDTH-1:0] = prescale;
            REG_COUNT:    rd_mux = count;
            REG_COMPARE:  rd_mux = compare;
            REG_STATUS:   rd_mux[0] = match;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl      <= '0;
            prescale  <= '0;
            count     <= '0;
            compare   <= '0;
            match     <= 1'b0;
            pre       <= '0;
            raddr_q   <= '0;
            read_data <= '0;
            started   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= write_data[2:0];
            end
            prescale  <= prescale_nxt;
            count     <= count_nxt;
            compare   <= compare_nxt;
            // A new match takes priority over a simultaneous W1C.
            match     <= match_hit | (match & ~clr_match);
            pre       <= pre_nxt;
            raddr_q   <= read_addr;
            read_data <= rd_mux;
            started   <= 1'b1;
        end
    end

    assign data_valid = rst && started && (read_addr == raddr_q);
    assign irq        = match & ctrl[2];

endmodule

// File: tb/tb_axi4_lite_timer.sv
// Scoreboard bench for axi4_lite_timer: reads push expected data into a queue,
// a negedge monitor pops and compares whenever data_valid is presented.
module tb_axi4_lite_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  byte_en = '0;
    logic [31:0] write_addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_addr = '0;
    logic [31:0] read_data;
    logic        data_valid;
    logic        irq;

    axi4_lite_timer #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .PRESCALE_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_write  (mem_write),
        .byte_en    (byte_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .data_valid (data_valid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   issue_cyc = 0;
    int   rd_issued = 0;
    int   rd_seen = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && data_valid && exp_q.size() > 0 && cyc > issue_cyc) begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, " addr"}, read_addr, mon_e.addr);
            check(mon_e.name, read_data, mon_e.data);
            rd_seen++;
        end
    end

    task automatic push_exp(input string name, input logic [31:0] addr, input logic [31:0] data);
        exp_t t;
        t.name = name;
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
        rd_issued++;
    endtask

    // Called at posedge+1; returns at posedge+1 once the monitor has drained the queue.
    task automatic wait_reads(input string name);
        for (int i = 0; i < 8 && rd_seen != rd_issued; i++) @(posedge clk);
        check({name, " read timeout"}, 32'(rd_seen == rd_issued), 32'd1);
        if (rd_seen != rd_issued) begin
            exp_q.delete();
            rd_issued = rd_seen;
        end
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic changed;
        changed   = (addr != read_addr);
        read_addr = addr;
        issue_cyc = cyc;
        push_exp(name, addr, exp);
        if (changed) begin
            @(negedge clk);
            check({name, " dv drop"}, {31'b0, data_valid}, 32'd0);
        end
        wait_reads(name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        mem_write  = 1'b1;
        write_addr = addr;
        write_data = data;
        byte_en    = be;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        byte_en   = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset / idle
        read_addr = 32'h08;
        cycles(5);
        check("reset read_data", read_data, 32'd0);
        check("reset dv", {31'b0, data_valid}, 32'd0);
        check("reset irq", {31'b0, irq}, 32'd0);
        rst = 1'b1;
        issue_cyc = cyc;
        push_exp("count after reset", 32'h08, 32'd0);
        @(negedge clk);
        check("dv first cycle", {31'b0, data_valid}, 32'd0);
        wait_reads("count after reset");
        check("idle irq", {31'b0, irq}, 32'd0);

        // Byte-enable writes
        wr(32'h0C, 32'hAABBCCDD, 4'b0101);
        do_read(32'h0C, 32'h00BB00DD, "compare be0101");
        wr(32'h0C, 32'hFFFFFFFF, 4'b0000);
        do_read(32'h0C, 32'h00BB00DD, "compare be0000");
        wr(32'h04, 32'hFFFF1234, 4'hF);
        do_read(32'h04, 32'h00001234, "prescale width");

        // Same-cycle write/read of COMPARE: old value then new value
        read_addr  = 32'h0C;
        issue_cyc  = cyc;
        push_exp("compare rw old", 32'h0C, 32'h00BB00DD);
        push_exp("compare rw new", 32'h0C, 32'h12345678);
        wr(32'h0C, 32'h12345678, 4'hF);
        wait_reads("compare rw");

        // Free-run match, no reload
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h0C, 32'd5, 4'hF);
        wr(32'h00, 32'h5, 4'h1);
        cycles(5);
        check("freerun irq before", {31'b0, irq}, 32'd0);
        cycles(1);
        check("freerun irq at match", {31'b0, irq}, 32'd1);
        wr(32'h00, 32'h4, 4'h1);
        do_read(32'h08, 32'd7, "freerun count continues");
        do_read(32'h10, 32'd1, "freerun status");
        wr(32'h00, 32'h0, 4'h1);
        check("irq_en clear", {31'b0, irq}, 32'd0);
        wr(32'h10, 32'h0, 4'hF);
        do_read(32'h10, 32'd1, "status write0");
        wr(32'h10, 32'h1, 4'hF);
        do_read(32'h10, 32'd0, "status w1c");

        // Auto-reload with prescale
        wr(32'h04, 32'd3, 4'hF);
        wr(32'h0C, 32'd2, 4'hF);
        wr(32'h08, 32'd0, 4'hF);
        wr(32'h00, 32'h7, 4'h1);
        cycles(11);
        check("reload irq before", {31'b0, irq}, 32'd0);
        cycles(1);
        check("reload irq at match", {31'b0, irq}, 32'd1);
        cycles(11);
        wr(32'h10, 32'h1, 4'h1);
        check("w1c vs set", {31'b0, irq}, 32'd1);
        wr(32'h10, 32'h1, 4'h1);
        check("w1c clear irq", {31'b0, irq}, 32'd0);
        wr(32'h00, 32'h0, 4'h1);
        do_read(32'h08, 32'd0, "reload count");

        // COUNT write racing a tick
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h00, 32'h1, 4'h1);
        wr(32'h08, 32'h100, 4'hF);
        wr(32'h00, 32'h0, 4'h1);
        do_read(32'h0C, 32'd2, "compare hold");
        do_read(32'h08, 32'h101, "count write wins");
        wr(32'h00, 32'h1, 4'h1);
        wr(32'h08, 32'h0000AB00, 4'b0010);
        wr(32'h00, 32'h0, 4'h1);
        do_read(32'h04, 32'd0, "prescale zero");
        do_read(32'h08, 32'h0000AB03, "count partial write");

        // Wrap without match; unmapped access
        wr(32'h0C, 32'h10, 4'hF);
        wr(32'h08, 32'hFFFFFFFF, 4'hF);
        wr(32'h00, 32'h1, 4'h1);
        wr(32'h00, 32'h0, 4'h1);
        do_read(32'h10, 32'd0, "wrap no match");
        do_read(32'h08, 32'd0, "wrap count");
        wr(32'h18, 32'hFFFFFFFF, 4'hF);
        do_read(32'h18, 32'd0, "unmapped");
        do_read(32'h00, 32'd0, "ctrl after unmapped wr");

        // Reset mid-operation
        wr(32'h0C, 32'd0, 4'hF);
        wr(32'h00, 32'h5, 4'h1);
        cycles(2);
        check("pre-reset irq", {31'b0, irq}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async reset irq", {31'b0, irq}, 32'd0);
        check("async reset dv", {31'b0, data_valid}, 32'd0);
        check("async reset rdata", read_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_read(32'h08, 32'd0, "count after mid reset");
        do_read(32'h00, 32'd0, "ctrl after mid reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
